aes_key_expand: RTL and testbench

Iterative AES-128 key-schedule generator that sits directly upstream of the `Round` stage. It accepts a 128-bit cipher key and emits round keys 0..10 one at a time on `round_key`, qualified by `key_valid_out`. The consumer pulls each key with `key_ready_in`. One round key is derived per accepted handshake, from the previous key, using four S-box lookups and one Rcon constant.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_sbox.sv | 17 +
 rtl/aes_key_expand.sv | 123 ++++++++++++
 tb/tb_aes_key_expand.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 shared constants, S-box table and key-schedule state type
//
// Purpose: common definitions for the AES-128 datapath blocks.
// Contents: NR (round count), 32-bit word slicing positions within a 128-bit
//           state/key (w0 is the most significant word), Rcon table indexed by
//           round number, the forward S-box table and the key-schedule FSM state.
// Ports:    none (package).

package aes_pkg;

    localparam int NR     = 10;
    localparam int WORD_W = 32;

    // Word positions inside a 128-bit key: w0 = [127:96] ... w3 = [31:0]
    localparam int W0_LSB = 96;
    localparam int W1_LSB = 64;
    localparam int W2_LSB = 32;
    localparam int W3_LSB = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_t;

    // Rcon[r] for r = 1..10; entry 0 and the tail are unused padding so that
    // any 4-bit round number indexes safely.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // RotWord([a,b,c,d]) = [b,c,d,a]
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[WORD_W-9:0], w[WORD_W-1:WORD_W-8]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box byte lookup
//
// Purpose: single-byte SubBytes substitution, shared by the key schedule
//          (SubWord) and the round datapath (SubBytes).
// Ports:   i_byte - input byte
//          o_byte - substituted byte

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 round-key generator, one key per handshake
//
// Purpose: accepts a 128-bit cipher key and emits round keys 0..NR one at a
//          time; each accepted key derives the next in a single combinational
//          stage (RotWord, 4x S-box, Rcon, XOR chain).
// Ports:   clk, reset            - clock, synchronous active-high reset
//          key_valid_in, key_in  - cipher key offer, taken only while idle
//          key_ready_in          - consumer takes round_key this cycle
//          round_key, round_idx  - current round key and its index 0..NR
//          key_valid_out         - round_key/round_idx valid
//          busy                  - expansion in progress, new keys ignored
//          done                  - one-cycle pulse after key NR is consumed

module aes_key_expand #(
    parameter int DATA_W = 128,
    parameter int NR     = aes_pkg::NR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_ready_in,
    output logic [DATA_W-1:0] round_key,
    output logic [3:0]        round_idx,
    output logic              key_valid_out,
    output logic              busy,
    output logic              done
);

    import aes_pkg::*;

    ks_state_t         r_state;
    logic [DATA_W-1:0] r_key;
    logic [3:0]        r_idx;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic [WORD_W-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [WORD_W-1:0] w_rot;
    logic [WORD_W-1:0] w_sub;
    logic [WORD_W-1:0] w_t;
    logic [WORD_W-1:0] w_nw0, w_nw1, w_nw2, w_nw3;
    logic [DATA_W-1:0] w_next_key;
    logic [3:0]        w_idx_next;
    logic              w_handshake;
    logic              w_last;

    assign w_w0 = r_key[W0_LSB +: WORD_W];
    assign w_w1 = r_key[W1_LSB +: WORD_W];
    assign w_w2 = r_key[W2_LSB +: WORD_W];
    assign w_w3 = r_key[W3_LSB +: WORD_W];

    assign w_rot = rot_word(w_w3);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Rcon is selected by the index of the key being produced, not the current one
    assign w_idx_next = r_idx + 4'd1;
    assign w_t        = w_sub ^ {RCON[w_idx_next], 24'h000000};

    // Each new word folds in the previously computed new word, not the old one
    assign w_nw0 = w_w0 ^ w_t;
    assign w_nw1 = w_w1 ^ w_nw0;
    assign w_nw2 = w_w2 ^ w_nw1;
    assign w_nw3 = w_w3 ^ w_nw2;

    assign w_next_key  = {w_nw0, w_nw1, w_nw2, w_nw3};
    assign w_handshake = r_valid && key_ready_in;
    assign w_last      = (r_idx == 4'(NR));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (key_valid_in) begin
                        r_key   <= key_in;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    // key_valid_in is deliberately not looked at here, so a key
                    // offered in the final-handshake cycle is dropped
                    if (w_handshake) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_key <= w_next_key;
                            r_idx <= w_idx_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign round_key     = r_key;
    assign round_idx     = r_idx;
    assign key_valid_out = r_valid;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - self-checking bench for aes_key_expand

module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid_in;
    logic [127:0] key_in;
    logic         key_ready_in;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid_out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes_key_expand #(.DATA_W(128), .NR(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid_in  (key_valid_in),
        .key_in        (key_in),
        .key_ready_in  (key_ready_in),
        .round_key     (round_key),
        .round_idx     (round_idx),
        .key_valid_out (key_valid_out),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] idx1;
        logic [127:0] idx10;
    } vec_t;

    vec_t         vecs [2];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   ref_sbox [256];
    logic [127:0] exp_rk [11];
    logic [127:0] cap [11];
    int           done_cyc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then affine map
    task automatic init_ref();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-array key schedule w[0..43]; round key r = w[4r..4r+3]
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]}
                  ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Offer a key, consume all round keys and check each against the model.
    // poke re-offers a different key at idx 5 and in the final-handshake cycle.
    task automatic expand_and_check(input logic [127:0] key, input bit rand_ready, input bit poke);
        int nxt;
        bit fin;
        bit rdy;
        model_expand(key);
        done_cyc     = -1;
        key_in       = key;
        key_valid_in = 1'b1;
        key_ready_in = 1'b0;
        step();
        key_valid_in = 1'b0;
        nxt = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (done) begin
                chk("done_after_all_keys", 128'(nxt), 128'(11));
                chk("busy_at_done", 128'(busy), 128'(0));
                chk("valid_at_done", 128'(key_valid_out), 128'(0));
                done_cyc     = cyc;
                fin          = 1'b1;
                key_valid_in = 1'b0;
                key_ready_in = 1'b0;
            end else begin
                chk("valid_during", 128'(key_valid_out), 128'(1));
                chk("busy_during", 128'(busy), 128'(1));
                chk("round_idx", 128'(round_idx), 128'(nxt));
                chk("round_key", round_key, (nxt <= 10) ? exp_rk[nxt] : '1);
                if (nxt <= 10) cap[nxt] = round_key;
                rdy          = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                key_ready_in = rdy;
                key_valid_in = poke && ((round_idx == 4'd5) || (round_idx == 4'd10 && rdy));
                key_in       = poke ? ~key : key;
                if (rdy) nxt++;
                step();
            end
        end
        if (!fin) chk("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic check_idle_after();
        step();
        chk("done_one_cycle", 128'(done), 128'(0));
        chk("busy_after_done", 128'(busy), 128'(0));
        chk("valid_after_done", 128'(key_valid_out), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           bad;
        logic [127:0] rkey;

        init_ref();
        vecs[0] = '{key:   128'h2b7e151628aed2a6abf7158809cf4f3c,
                    idx1:  128'ha0fafe1788542cb123a339392a6c7605,
                    idx10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{key:   128'h000102030405060708090a0b0c0d0e0f,
                    idx1:  128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                    idx10: 128'h13111d7fe3944a17f307a78b4d2b30c5};

        reset        = 1'b1;
        key_valid_in = 1'b0;
        key_in       = '0;
        key_ready_in = 1'b0;
        repeat (3) step();
        chk("rst_round_key", round_key, 128'(0));
        chk("rst_round_idx", 128'(round_idx), 128'(0));
        chk("rst_valid", 128'(key_valid_out), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        reset = 1'b0;
        step();
        chk("idle_busy", 128'(busy), 128'(0));

        // Known-answer vectors, ready tied high
        for (int i = 0; i < 2; i++) begin
            expand_and_check(vecs[i].key, 1'b0, 1'b0);
            chk("kat_idx0", cap[0], vecs[i].key);
            chk("kat_idx1", cap[1], vecs[i].idx1);
            chk("kat_idx10", cap[10], vecs[i].idx10);
            chk("kat_done_cycle", 128'(done_cyc), 128'(11));
            check_idle_after();
        end

        // Random keys under random backpressure
        for (int k = 0; k < 6; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            expand_and_check(rkey, 1'b1, 1'b0);
            check_idle_after();
        end
        expand_and_check(vecs[0].key, 1'b1, 1'b0);
        chk("bp_kat_idx10", cap[10], vecs[0].idx10);
        check_idle_after();

        // Keys offered while busy are dropped; a key right after done is taken
        expand_and_check(vecs[1].key, 1'b1, 1'b1);
        chk("poke_idx10", cap[10], vecs[1].idx10);
        expand_and_check(vecs[0].key, 1'b0, 1'b0);
        chk("after_done_idx1", cap[1], vecs[0].idx1);
        chk("after_done_cycle", 128'(done_cyc), 128'(11));
        check_idle_after();

        // Reset in the middle of an expansion
        key_in       = vecs[1].key;
        key_valid_in = 1'b1;
        step();
        key_valid_in = 1'b0;
        key_ready_in = 1'b1;
        for (int c = 0; c < 20 && round_idx != 4'd4; c++) step();
        chk("mid_reach_idx4", 128'(round_idx), 128'(4));
        reset = 1'b1;
        step();
        reset        = 1'b0;
        key_ready_in = 1'b0;
        chk("abort_valid", 128'(key_valid_out), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_round_idx", 128'(round_idx), 128'(0));
        chk("abort_round_key", round_key, 128'(0));
        bad = 1'b0;
        key_ready_in = 1'b1;
        repeat (15) begin
            step();
            if (done || busy || key_valid_out) bad = 1'b1;
        end
        key_ready_in = 1'b0;
        chk("abort_stays_idle", 128'(bad), 128'(0));
        expand_and_check(vecs[0].key, 1'b1, 1'b0);
        chk("post_abort_idx1", cap[1], vecs[0].idx1);
        chk("post_abort_idx10", cap[10], vecs[0].idx10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
